// File: rtl/mem_access_unit_if.sv
// Request/grant/response memory bus between the load/store unit (master) and memory (slave).
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: drives a request/grant/response bus, stalls the pipeline
// until the access completes and returns lane-aligned, sign/zero-extended load data.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              fault,
    output logic              bus_err,
    mem_access_unit_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic [2:0]  ld_fmt;
    logic [1:0]  ld_off;

    logic        req_any;
    logic        illegal;
    logic        misaligned;
    logic        accept;
    logic        expired;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt_data;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        illegal     = 1'b1;
        be_next     = 4'b1111;
        wdata_next  = wdata;
        ld_byte     = bus.bus_rdata[7:0];
        ld_fmt_data = bus.bus_rdata;

        // Unsigned sizes only exist for loads; the store flag wins when both enables are high.
        case (funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = wr_en;
            default:                illegal = 1'b1;
        endcase
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        req_any    = rd_en | wr_en;
        accept     = (state == S_IDLE) && req_any && !illegal && !misaligned;
        stall      = reset && (accept || (state == S_REQ) || (state == S_WAIT));
        fault      = reset && (state == S_IDLE) && req_any && (illegal || misaligned);
        expired    = (tmo_cnt == LAST_CYCLE);

        case (funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: ;
        endcase

        case (ld_off)
            2'b00: ld_byte = bus.bus_rdata[7:0];
            2'b01: ld_byte = bus.bus_rdata[15:8];
            2'b10: ld_byte = bus.bus_rdata[23:16];
            2'b11: ld_byte = bus.bus_rdata[31:24];
        endcase
        ld_half = ld_off[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

        case (ld_fmt)
            3'b000:  ld_fmt_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt_data = {24'd0, ld_byte};
            3'b101:  ld_fmt_data = {16'd0, ld_half};
            default: ld_fmt_data = bus.bus_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            tmo_cnt       <= '0;
            ld_fmt        <= '0;
            ld_off        <= '0;
            ld_data       <= '0;
            bus_err       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
        end else begin
            bus_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        state         <= S_REQ;
                        tmo_cnt       <= '0;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= wr_en;
                        bus.bus_addr  <= {addr[31:2], 2'b00};
                        bus.bus_be    <= be_next;
                        bus.bus_wdata <= wdata_next;
                        ld_fmt        <= funct3;
                        ld_off        <= addr[1:0];
                    end
                end
                S_REQ: begin
                    // A response arriving together with the grant is deliberately dropped.
                    if (bus.bus_gnt) begin
                        bus.bus_req <= 1'b0;
                        tmo_cnt     <= '0;
                        state       <= bus.bus_we ? S_DONE : S_WAIT;
                    end else if (expired) begin
                        bus.bus_req <= 1'b0;
                        ld_data     <= '0;
                        bus_err     <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (bus.bus_rvalid) begin
                        ld_data <= ld_fmt_data;
                        state   <= S_DONE;
                    end else if (expired) begin
                        ld_data <= '0;
                        bus_err <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_DONE: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a size/offset arithmetic model.
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall;
    logic        fault;
    logic        bus_err;
    logic [31:0] ld_data;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model_ld = 32'd0;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .funct3  (funct3),
        .addr    (addr),
        .wdata   (wdata),
        .stall   (stall),
        .ld_data (ld_data),
        .fault   (fault),
        .bus_err (bus_err),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    function automatic int m_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_mask(input int sz);
        return (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = m_size(f3);
        return 4'(((1 << sz) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz;
        logic [31:0] r;
        sz = m_size(f3);
        r = 32'd0;
        for (int i = 0; i < 4 / sz; i++) r = r | ((wd & m_mask(sz)) << (8 * sz * i));
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
        int sz;
        logic [31:0] msk;
        logic [31:0] v;
        sz  = m_size(f3);
        msk = m_mask(sz);
        v   = (word >> (8 * int'(a[1:0]))) & msk;
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~msk;
        return v;
    endfunction

    task automatic idle();
        @(posedge clk); #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
    endtask

    // One full access; gd/rd are extra cycles before grant/response (>= TO means never).
    task automatic do_access(input bit st, input bit both, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input int gd,
                             input int rd, input bit rv_with_gnt, input logic [31:0] word);
        bit          load, req_to, wait_to, err, exp_req;
        int          req_cycles, wait_cycles, total, rv_k;
        logic [31:0] exp_ld;
        load        = !st;
        req_to      = (gd >= TO);
        req_cycles  = req_to ? TO : gd + 1;
        wait_to     = load && !req_to && (rd >= TO);
        wait_cycles = (!load || req_to) ? 0 : (wait_to ? TO : rd + 1);
        total       = 1 + req_cycles + wait_cycles;
        err         = req_to || wait_to;
        rv_k        = req_cycles + 1 + rd;
        exp_ld      = err ? 32'd0 : (load ? m_load(f3, a, word) : model_ld);
        for (int k = 0; k <= total; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                rd_en  = !st || both;
                wr_en  = st;
                funct3 = f3;
                addr   = a;
                wdata  = wd;
            end
            bus_if.bus_gnt    = !req_to && (k == gd + 1);
            bus_if.bus_rvalid = (load && !req_to && !wait_to && k == rv_k) ||
                                (rv_with_gnt && k == gd + 1);
            bus_if.bus_rdata  = (k == rv_k) ? word : $urandom;
            @(negedge clk);
            exp_req = (k >= 1) && (k <= req_cycles);
            n_checks++;
            if (stall !== (k < total))
                $display("FAIL stall f3=%b a=%h k=%0d: got %b want %b", f3, a, k, stall, k < total);
            else n_pass++;
            n_checks++;
            if (bus_if.bus_req !== exp_req)
                $display("FAIL bus_req f3=%b a=%h k=%0d: got %b want %b", f3, a, k, bus_if.bus_req, exp_req);
            else n_pass++;
            if (exp_req) begin
                n_checks++;
                if (bus_if.bus_addr !== {a[31:2], 2'b00})
                    $display("FAIL bus_addr k=%0d: got %h want %h", k, bus_if.bus_addr, {a[31:2], 2'b00});
                else n_pass++;
                n_checks++;
                if (bus_if.bus_be !== m_be(f3, a))
                    $display("FAIL bus_be f3=%b a=%h: got %b want %b", f3, a, bus_if.bus_be, m_be(f3, a));
                else n_pass++;
                n_checks++;
                if (bus_if.bus_we !== st)
                    $display("FAIL bus_we a=%h: got %b want %b", a, bus_if.bus_we, st);
                else n_pass++;
                if (st) begin
                    n_checks++;
                    if (bus_if.bus_wdata !== m_wdata(f3, wd))
                        $display("FAIL bus_wdata f3=%b wd=%h: got %h want %h", f3, wd, bus_if.bus_wdata, m_wdata(f3, wd));
                    else n_pass++;
                end
            end
            if (k == 0) begin
                n_checks++;
                if (fault !== 1'b0) $display("FAIL fault on legal access a=%h: got %b want 0", a, fault);
                else n_pass++;
            end
            n_checks++;
            if (bus_err !== ((k == total) && err))
                $display("FAIL bus_err k=%0d: got %b want %b", k, bus_err, (k == total) && err);
            else n_pass++;
            if (k == total) begin
                n_checks++;
                if (ld_data !== exp_ld)
                    $display("FAIL ld_data f3=%b a=%h word=%h: got %h want %h", f3, a, word, ld_data, exp_ld);
                else n_pass++;
            end
        end
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        model_ld = exp_ld;
    endtask

    task automatic test_reset();
        rd_en = 1'b1; funct3 = 3'b010; addr = 32'h100;
        #2;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL reset stall: got %b want 0", stall); else n_pass++;
        addr = 32'h101;
        #1;
        n_checks++;
        if (fault !== 1'b0) $display("FAIL reset fault: got %b want 0", fault); else n_pass++;
        n_checks++;
        if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be, bus_err} !== 7'd0)
            $display("FAIL reset ctrl: got %b want 0", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_be, bus_err});
        else n_pass++;
        n_checks++;
        if ({bus_if.bus_addr, bus_if.bus_wdata, ld_data} !== 96'd0)
            $display("FAIL reset data: got %h want 0", {bus_if.bus_addr, bus_if.bus_wdata, ld_data});
        else n_pass++;
        @(posedge clk); #1;
        rd_en = 1'b0;
        reset = 1'b1;
        model_ld = 32'd0;
    endtask

    task automatic test_lw();
        do_access(1'b0, 1'b0, 3'b010, 32'h100, 32'd0, 0, 0, 1'b0, 32'hDEAD_BEEF);
        n_checks++;
        if (ld_data !== 32'hDEAD_BEEF) $display("FAIL lw_value: got %h want deadbeef", ld_data);
        else n_pass++;
    endtask

    task automatic test_load_formats();
        do_access(1'b0, 1'b0, 3'b000, 32'h103, 32'd0, 0, 0, 1'b0, 32'h80FF_1234);
        n_checks++;
        if (ld_data !== 32'hFFFF_FF80) $display("FAIL lb_value: got %h want ffffff80", ld_data);
        else n_pass++;
        do_access(1'b0, 1'b0, 3'b100, 32'h103, 32'd0, 1, 2, 1'b1, 32'h80FF_1234);
        n_checks++;
        if (ld_data !== 32'h0000_0080) $display("FAIL lbu_value: got %h want 00000080", ld_data);
        else n_pass++;
        do_access(1'b0, 1'b0, 3'b001, 32'h102, 32'd0, 0, 1, 1'b0, 32'h80FF_1234);
        n_checks++;
        if (ld_data !== 32'hFFFF_80FF) $display("FAIL lh_value: got %h want ffff80ff", ld_data);
        else n_pass++;
        do_access(1'b0, 1'b0, 3'b101, 32'h202, 32'd0, 0, 0, 1'b0, 32'h9ABC_0001);
        idle();
    endtask

    task automatic test_store();
        do_access(1'b1, 1'b0, 3'b000, 32'h201, 32'h0000_00A5, 3, 0, 1'b0, 32'd0);
        do_access(1'b1, 1'b1, 3'b001, 32'h302, 32'h1234_5678, 0, 0, 1'b1, 32'd0);
        idle();
    endtask

    task automatic test_fault();
        typedef struct packed {logic rd; logic wr; logic [2:0] f3; logic [31:0] a;} fvec_t;
        fvec_t vecs [8];
        vecs[0] = '{1'b1, 1'b0, 3'b010, 32'h0000_0102};
        vecs[1] = '{1'b0, 1'b1, 3'b001, 32'h0000_0301};
        vecs[2] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100};
        vecs[3] = '{1'b0, 1'b1, 3'b100, 32'h0000_0100};
        vecs[4] = '{1'b1, 1'b0, 3'b110, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b0, 3'b101, 32'h0000_0103};
        vecs[6] = '{1'b1, 1'b1, 3'b101, 32'h0000_0100};
        vecs[7] = '{1'b0, 1'b1, 3'b010, 32'h0000_0201};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rd_en = vecs[i].rd; wr_en = vecs[i].wr; funct3 = vecs[i].f3; addr = vecs[i].a;
            @(negedge clk);
            n_checks++;
            if ({fault, stall, bus_if.bus_req} !== 3'b100)
                $display("FAIL fault_vec%0d {fault,stall,req}: got %b want 100", i, {fault, stall, bus_if.bus_req});
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({bus_if.bus_req, ld_data} !== {1'b0, model_ld})
                $display("FAIL fault_hold%0d {req,ld}: got %h want %h", i, {bus_if.bus_req, ld_data}, {1'b0, model_ld});
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_timeout();
        do_access(1'b0, 1'b0, 3'b010, 32'h440, 32'd0, 0, 99, 1'b0, 32'h5555_AAAA);
        @(posedge clk); #1;
        rd_en = 1'b0;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if ({ld_data, stall, bus_if.bus_req, bus_err} !== 35'd0)
            $display("FAIL late_rvalid {ld,stall,req,err}: got %h want 0", {ld_data, stall, bus_if.bus_req, bus_err});
        else n_pass++;
        do_access(1'b1, 1'b0, 3'b010, 32'h480, 32'hFEED_0001, 99, 0, 1'b0, 32'd0);
        idle();
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b0, 3'b010, 32'h1000, 32'd0, 1, 0, 1'b0, 32'h0BAD_F00D);
        do_access(1'b1, 1'b0, 3'b010, 32'h1004, 32'hC001_D00D, 0, 0, 1'b0, 32'd0);
        do_access(1'b0, 1'b0, 3'b100, 32'h1006, 32'd0, 0, 0, 1'b0, 32'h00F1_0000);
        do_access(1'b1, 1'b0, 3'b001, 32'h100A, 32'h0000_BEEF, 2, 0, 1'b0, 32'd0);
        idle();
    endtask

    task automatic test_random();
        logic [2:0]  lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = st ? lf[$urandom_range(0, 2)] : lf[$urandom_range(0, 4)];
            a  = $urandom;
            a  = a & ~32'(m_size(f3) - 1);
            do_access(st, 1'($urandom_range(0, 1)), f3, a, $urandom, int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_access(1'b0, 1'b0, 3'b010, 32'h500, 32'd0, 0, 0, 1'b0, 32'h1357_9BDF);
        @(posedge clk); #1;
        rd_en = 1'b1; wr_en = 1'b0; funct3 = 3'b010; addr = 32'h400;
        @(posedge clk); #1;
        bus_if.bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_gnt = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({stall, ld_data} !== {1'b1, 32'h1357_9BDF})
            $display("FAIL pre_reset {stall,ld}: got %h want 11357_9bdf", {stall, ld_data});
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus_if.bus_req, stall, ld_data} !== 34'd0)
            $display("FAIL mid_reset {req,stall,ld}: got %h want 0", {bus_if.bus_req, stall, ld_data});
        else n_pass++;
        rd_en = 1'b0;
        @(posedge clk); #1;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'hCAFE_F00D;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ld_data, stall, bus_if.bus_req} !== 34'd0)
            $display("FAIL post_reset_rvalid {ld,stall,req}: got %h want 0", {ld_data, stall, bus_if.bus_req});
        else n_pass++;
        bus_if.bus_rvalid = 1'b0;
        model_ld = 32'd0;
        do_access(1'b0, 1'b0, 3'b010, 32'h600, 32'd0, 0, 0, 1'b0, 32'h2468_ACE0);
        idle();
    endtask

    initial begin
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = 32'd0;
        test_reset();
        test_lw();
        test_load_formats();
        test_store();
        test_fault();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
